// File: rtl/yamips_mem_pkg.sv
// Shared definitions for the YAMIPS memory-side port sequencer.
package yamips_mem_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WADDR = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RADDR = ST_RADDR,
    RDATA = ST_RDATA,
    WADDR = ST_WADDR,
    WRESP = ST_WRESP,
    DONE  = ST_DONE
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-beat MEM-side port of MEM_to_AXI_Bridge, shared address for AW and AR.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Valid/ready: a beat transfers on a rising edge where both are high; once a
  // valid is raised it stays high, with its payload unchanged, until that edge.
  logic [ADDR_WIDTH-1:0] S_ARWADDR;
  logic                  S_AWVALID;
  logic                  S_AWREADY;
  logic [DATA_WIDTH-1:0] S_WDATA;
  logic                  S_WVALID;
  logic                  S_WREADY;
  logic                  S_BVALID;
  logic                  S_BREADY;
  logic                  S_ARVALID;
  logic                  S_ARREADY;
  logic [DATA_WIDTH-1:0] S_RDATA;
  logic                  S_RVALID;
  logic                  S_RREADY;

  modport master (
    output S_ARWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RDATA, S_RVALID
  );

  modport slave (
    input  S_ARWADDR, S_AWVALID, S_WDATA, S_WVALID, S_BREADY, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RDATA, S_RVALID
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the grant favours the port not served last.
module rr_arb2
  import yamips_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt
);

  logic last;

  always_comb begin
    gnt = GNT_I;
    if (req == 2'b11) gnt = ~last;
    else if (req[GNT_D]) gnt = GNT_D;
  end

  always_ff @(posedge clk) begin
    if (rst) last <= GNT_I;
    else if (advance) last <= gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the bridge MEM port between instruction fetch and data access,
// running one single-beat read or write at a time.
module mem_port_arbiter
  import yamips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  mem_port_arbiter_if.master    bus,
  output state_t                state_dbg
);

  state_t                state, state_nx;
  logic                  gnt, gnt_q, advance, aw_ok, w_ok;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // Requester inputs only matter in IDLE; afterwards everything runs off latched copies.
  assign advance = (state == IDLE) && (i_req || d_req);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({d_req, i_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  assign bus.S_ARWADDR = addr_q;
  assign bus.S_WDATA   = wdata_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.S_ARVALID = 1'b0;
    bus.S_RREADY  = 1'b0;
    bus.S_AWVALID = 1'b0;
    bus.S_WVALID  = 1'b0;
    bus.S_BREADY  = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    case (state)
      IDLE: if (advance) state_nx = (gnt == GNT_D && d_we) ? WADDR : RADDR;
      RADDR: begin
        bus.S_ARVALID = 1'b1;
        if (bus.S_ARREADY) state_nx = RDATA;
      end
      RDATA: begin
        bus.S_RREADY = 1'b1;
        if (bus.S_RVALID) state_nx = DONE;
      end
      WADDR: begin
        // AW and W complete independently; leave once both have been seen.
        bus.S_AWVALID = ~aw_ok;
        bus.S_WVALID  = ~w_ok;
        if ((aw_ok || bus.S_AWREADY) && (w_ok || bus.S_WREADY)) state_nx = WRESP;
      end
      WRESP: begin
        bus.S_BREADY = 1'b1;
        if (bus.S_BVALID) state_nx = DONE;
      end
      DONE: begin
        i_done   = (gnt_q == GNT_I);
        d_done   = (gnt_q == GNT_D);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= GNT_I;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (advance) begin
          gnt_q <= gnt;
          aw_ok <= 1'b0;
          w_ok  <= 1'b0;
          if (gnt == GNT_D) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
          end else begin
            addr_q  <= i_addr;
          end
        end
        WADDR: begin
          aw_ok <= aw_ok | bus.S_AWREADY;
          w_ok  <= w_ok | bus.S_WREADY;
        end
        RDATA: if (bus.S_RVALID) begin
          if (gnt_q == GNT_D) d_rdata <= bus.S_RDATA;
          else                i_rdata <= bus.S_RDATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single MEM-side port of `MEM_to_AXI_Bridge` between the CPU instruction-fetch port (read-only) and data port (read/write). It sits between the YAMIPS core and the bridge. It grants one requester at a time using round-robin, drives the bridge's AW/W/B/AR/R handshakes for one single-beat transaction, and returns read data plus a one-cycle done pulse to the winner.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width on both requester ports and the bridge side.
- `DATA_WIDTH`, 32, data width; must be 32 to match the bridge.

Ports: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: instruction read request; held high until `i_done`.
- `i_addr` in 32: fetch address; stable while `i_req` is high.
- `i_rdata` out 32: fetched word; valid while `i_done` is high.
- `i_done` out 1: one-cycle completion pulse.
- `d_req` in 1: data request; held high until `d_done`.
- `d_we` in 1: 1 = write, 0 = read; stable with `d_req`.
- `d_addr` in 32: data address.
- `d_wdata` in 32: write data.
- `d_rdata` out 32: read data; valid while `d_done` is high.
- `d_done` out 1: one-cycle completion pulse.
- `S_ARWADDR` out 32, `S_AWVALID` out 1, `S_AWREADY` in 1, `S_WDATA` out 32, `S_WVALID` out 1, `S_WREADY` in 1, `S_BVALID` in 1, `S_BREADY` out 1, `S_ARVALID` out 1, `S_ARREADY` in 1, `S_RDATA` in 32, `S_RVALID` in 1, `S_RREADY` out 1: bridge MEM-side port.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- **IDLE:** if any request is pending, grant one and latch its address, write data and direction into registers. `i_req` always means read.
  - Next state is RADDR for a read, WADDR for a write.
- **Arbitration:** 1-bit `last` pointer, reset to "instruction".
  - If both requests are pending, grant the port that is not `last`.
  - `last` updates on every grant.
- **RADDR:** `S_ARVALID`=1. Go to RDATA on `S_ARREADY`.
- **RDATA:** `S_RREADY`=1. On `S_RVALID`, register `S_RDATA` into the granted port's rdata register and go to DONE.
- **WADDR:** `S_AWVALID` and `S_WVALID` rise together.
  - Each valid drops after its own ready is seen; track with `aw_ok` and `w_ok` flags.
  - Go to WRESP in the cycle both handshakes are complete. This includes AW and W completing in the same cycle, or in different cycles in either order.
- **WRESP:** `S_BREADY`=1. Go to DONE on `S_BVALID`.
- **DONE:** pulse the granted port's done for one cycle, then go to IDLE.
  - The requester must drop `req` during the done cycle.
  - A `req` still high in the following IDLE cycle is a new request.
- `S_ARWADDR` and `S_WDATA` come from the latched registers and are held for the entire transaction.
- `d_rdata`/`i_rdata` keep their value until the next read completes on that port.
- Write transactions never update `d_rdata`.
- Requests that arrive mid-transaction wait. Requester inputs outside IDLE are ignored.

## Timing
- **Reset values:** state IDLE; all S_* valids/readies 0; done outputs 0; rdata registers 0; `S_ARWADDR`/`S_WDATA` 0; `last` = instruction.
- All outputs are registered or decoded from registered state only. There is no combinational path from requester inputs to S_* outputs.
- **Read, zero wait:**
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `S_ARVALID` high, `S_ARREADY` high.
  - Cycle 2: `S_RREADY` high, `S_RVALID` high.
  - Cycle 3: done high.
  - Cycle 4: IDLE.
  - Minimum latency is 3 cycles from request to done.
- **Write, zero wait:**
  - Cycle 1: AW and W accepted.
  - Cycle 2: `S_BVALID` high.
  - Cycle 3: done high.
- Each wait cycle on any ready/valid adds one cycle.
- Valids never drop before their handshake completes. The latched address and data do not change while a valid is high.
- **Reset mid-transaction:** return to IDLE immediately and drop all valids. A reset is system-wide, so the slave is reset too.

## Structure
- Shared package `yamips_mem_pkg` holds:
  - the state encoding (6 states, 3-bit localparams);
  - the grant encoding (GNT_I=0, GNT_D=1);
  - the `DATA_WIDTH` constant.
- One natural sub-module: `rr_arb2`, a 2-request round-robin arbiter holding the `last` pointer.
  - Inputs: `req[1:0]` and `advance`.
  - Output: grant index.
- The FSM and the handshake flags stay in `mem_port_arbiter`.

## Test plan
- **Single fetch:** `i_req`, `i_addr`=0x0000_0040, slave returns 0x2402_0005 with zero waits -> `S_ARWADDR`=0x40, `i_done` at cycle 3, `i_rdata`=0x2402_0005, `d_done` stays 0.
- **Data write, W before AW:** `d_we`=1, `d_addr`=0x1000_0004, `d_wdata`=0xDEAD_BEEF, with `S_WREADY` in cycle 1 and `S_AWREADY` in cycle 3 -> `S_WVALID` drops after cycle 1, `S_AWVALID` drops after cycle 3, `S_BREADY` from cycle 4, `d_done` one cycle after `S_BVALID`.
- **Simultaneous requests from reset:** both `req` high at cycle 0 -> data granted first (since `last`=instruction), instruction granted in the IDLE right after `d_done`. Then re-raise both -> data granted again (`last`=instruction after the fetch).
- **Back-to-back fetch, `i_req` held through done:** second transaction starts in the cycle after IDLE. Exactly two `i_done` pulses for two requests.
- **Read with waits:** `S_ARREADY` delayed 4 cycles and `S_RVALID` delayed 3 cycles -> `S_ARVALID` and `S_ARWADDR` stable throughout, `S_RREADY` high only in RDATA, `d_done` exactly once.
- **Reset mid-write:** assert `rst` while in WRESP -> next cycle IDLE, all valids/readies 0, no done pulse. A subsequent request completes normally.
